// File: rtl/run_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM states, run-end causes, signature step.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RESET = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } run_state_t;

   // Why a RUN clock ends the run; abort outranks halt, halt outranks timeout.
   typedef enum logic [1:0] {
      END_NONE    = 2'd0,
      END_HALT    = 2'd1,
      END_TIMEOUT = 2'd2,
      END_ABORT   = 2'd3
   } end_cause_t;

   localparam logic [31:0] CYCLE_MAX = 32'hFFFF_FFFF;

   function automatic logic [31:0] sig_step(input logic [31:0] sig, input logic [31:0] pc_ext);
      return {sig[30:0], sig[31]} ^ pc_ext;
   endfunction

endpackage

// File: rtl/run_controller_stall_detector.sv
// Watches the fetch address during RUN and flags the clock on which the
// STALL_LIMIT-1'th consecutive unchanged-PC match occurs (combinational flag, registered history).
module stall_detector #(
   parameter int          PC_WIDTH    = 32,
   parameter int unsigned STALL_LIMIT = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                clear,
   input  logic                enable,
   input  logic [PC_WIDTH-1:0] pc,
   output logic                stalled
);

   localparam logic [15:0] LAST_CNT = 16'(STALL_LIMIT - 2);

   logic [PC_WIDTH-1:0] pc_q;
   logic [15:0]         match_cnt;
   logic                primed;
   logic                match;

   // The first enabled clock only loads pc_q, so no compare happens until primed.
   assign match   = primed && (pc == pc_q);
   assign stalled = enable && match && (match_cnt == LAST_CNT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q      <= '0;
         match_cnt <= '0;
         primed    <= 1'b0;
      end else if (clear) begin
         match_cnt <= '0;
         primed    <= 1'b0;
      end else if (enable) begin
         pc_q   <= pc;
         primed <= 1'b1;
         if (match) begin
            match_cnt <= match_cnt + 16'd1;
         end else begin
            match_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/run_controller.sv
// Sequences a CPU through reset pulse, bounded run and completion; ends on PC stall, budget or abort.
// Optional RUN_CTRL_SIGNATURE_EN adds a rotate-XOR signature of the fetched PCs.
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int          PC_WIDTH     = 32,
   parameter int unsigned RESET_CYCLES = 4,
   parameter int unsigned RUN_CYCLES   = 1000,
   parameter int unsigned STALL_LIMIT  = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [PC_WIDTH-1:0] pc,
   output logic                cpu_reset,
   output logic                running,
   output logic                done,
   output logic                halted,
   output logic                timeout,
   output logic [31:0]         cycle_count
`ifdef RUN_CTRL_SIGNATURE_EN
   ,
   output logic [31:0]         signature
`endif
);

   localparam logic [7:0]  RST_LAST  = 8'(RESET_CYCLES - 1);
   localparam logic [31:0] RUN_LIMIT = 32'(RUN_CYCLES);

   run_state_t  state;
   end_cause_t  cause;
   logic [7:0]  rst_cnt;
   logic [31:0] count_inc;
   logic        stalled;
   logic        det_clear;
   logic        det_enable;

   assign count_inc  = (cycle_count == CYCLE_MAX) ? cycle_count : cycle_count + 32'd1;
   assign det_clear  = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign det_enable = (state == ST_RUN);

   stall_detector #(
      .PC_WIDTH    (PC_WIDTH),
      .STALL_LIMIT (STALL_LIMIT)
   ) u_stall (
      .clock   (clock),
      .reset   (reset),
      .clear   (det_clear),
      .enable  (det_enable),
      .pc      (pc),
      .stalled (stalled)
   );

   always_comb begin
      cause = END_NONE;
      if (abort) begin
         cause = END_ABORT;
      end else if (stalled) begin
         cause = END_HALT;
      end else if (count_inc == RUN_LIMIT) begin
         cause = END_TIMEOUT;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         rst_cnt     <= '0;
         cpu_reset   <= 1'b1;
         running     <= 1'b0;
         done        <= 1'b0;
         halted      <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state       <= ST_RESET;
                  rst_cnt     <= RST_LAST;
                  done        <= 1'b0;
                  halted      <= 1'b0;
                  timeout     <= 1'b0;
                  cycle_count <= '0;
               end
            end
            ST_RESET: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (rst_cnt == 8'd0) begin
                  state     <= ST_RUN;
                  running   <= 1'b1;
                  cpu_reset <= 1'b0;
               end else begin
                  rst_cnt <= rst_cnt - 8'd1;
               end
            end
            ST_RUN: begin
               // The ending clock still counts as a RUN clock, including an aborted one.
               cycle_count <= count_inc;
               case (cause)
                  END_ABORT: begin
                     state     <= ST_IDLE;
                     running   <= 1'b0;
                     cpu_reset <= 1'b1;
                     halted    <= 1'b0;
                     timeout   <= 1'b0;
                  end
                  END_HALT: begin
                     state     <= ST_DONE;
                     running   <= 1'b0;
                     cpu_reset <= 1'b1;
                     done      <= 1'b1;
                     halted    <= 1'b1;
                     timeout   <= 1'b0;
                  end
                  END_TIMEOUT: begin
                     state     <= ST_DONE;
                     running   <= 1'b0;
                     cpu_reset <= 1'b1;
                     done      <= 1'b1;
                     halted    <= 1'b0;
                     timeout   <= 1'b1;
                  end
                  default: ;
               endcase
            end
            default: begin
               state     <= ST_IDLE;
               cpu_reset <= 1'b1;
               running   <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

`ifdef RUN_CTRL_SIGNATURE_EN
   logic [31:0] pc_ext;

   assign pc_ext = 32'(pc);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         signature <= '0;
      end else if (det_clear) begin
         signature <= '0;
      end else if (state == ST_RUN) begin
         signature <= sig_step(signature, pc_ext);
      end
   end
`endif

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: idle hold, timeout, stall halt, halt/timeout tie, abort, async reset.
module tb_run_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_a, abort_a, start_b, abort_b;
   logic [31:0] pc;

   logic        cpu_reset_a, running_a, done_a, halted_a, timeout_a;
   logic        cpu_reset_b, running_b, done_b, halted_b, timeout_b;
   logic [31:0] cycle_count_a, cycle_count_b;
`ifdef RUN_CTRL_SIGNATURE_EN
   logic [31:0] sig_a, sig_b;
`endif

   logic [4:0]  st_a, st_b;
   assign st_a = {cpu_reset_a, running_a, done_a, halted_a, timeout_a};
   assign st_b = {cpu_reset_b, running_b, done_b, halted_b, timeout_b};

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clock = ~clock;

   run_controller #(.PC_WIDTH(32), .RESET_CYCLES(4), .RUN_CYCLES(100), .STALL_LIMIT(8)) dut_a (
      .clock       (clock),
      .reset       (reset),
      .start       (start_a),
      .abort       (abort_a),
      .pc          (pc),
      .cpu_reset   (cpu_reset_a),
      .running     (running_a),
      .done        (done_a),
      .halted      (halted_a),
      .timeout     (timeout_a),
      .cycle_count (cycle_count_a)
`ifdef RUN_CTRL_SIGNATURE_EN
      , .signature (sig_a)
`endif
   );

   run_controller #(.PC_WIDTH(32), .RESET_CYCLES(4), .RUN_CYCLES(8), .STALL_LIMIT(8)) dut_b (
      .clock       (clock),
      .reset       (reset),
      .start       (start_b),
      .abort       (abort_b),
      .pc          (pc),
      .cpu_reset   (cpu_reset_b),
      .running     (running_b),
      .done        (done_b),
      .halted      (halted_b),
      .timeout     (timeout_b),
      .cycle_count (cycle_count_b)
`ifdef RUN_CTRL_SIGNATURE_EN
      , .signature (sig_b)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Status word {cpu_reset,running,done,halted,timeout}
   localparam logic [31:0] S_IDLE    = 32'h10;
   localparam logic [31:0] S_TIMEOUT = 32'h15;
   localparam logic [31:0] S_HALT    = 32'h16;

   initial begin
      reset = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0; pc = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;

      // Idle hold after reset
      for (int i = 0; i < 20; i++) begin
         tick;
         check("idle_st", 32'(st_a), S_IDLE);
         check("idle_cnt", cycle_count_a, 32'd0);
      end

      // Timeout run with pc += 4
      start_a = 1'b1; tick; start_a = 1'b0;
      check("t2_rst_st", 32'(st_a), S_IDLE);
      n = 0;
      while (!running_a && n < 20) begin tick; n++; end
      check("t2_rst_len", 32'(n), 32'd4);
      check("t2_cpu_rst", 32'(cpu_reset_a), 32'd0);
      n = 0;
      while (!done_a && n < 300) begin pc = 32'(n * 4); tick; n++; end
      check("t2_run_len", 32'(n), 32'd100);
      check("t2_st", 32'(st_a), S_TIMEOUT);
      check("t2_cnt", cycle_count_a, 32'd100);
      for (int i = 0; i < 5; i++) begin
         pc = 32'(i);
         tick;
         check("t2_hold_st", 32'(st_a), S_TIMEOUT);
         check("t2_hold_cnt", cycle_count_a, 32'd100);
      end

      // Stall halt: 10 advancing fetches then stuck at 0x28
      start_a = 1'b1; tick; start_a = 1'b0;
      check("t3_clr_st", 32'(st_a), S_IDLE);
      check("t3_clr_cnt", cycle_count_a, 32'd0);
      n = 0;
      while (!running_a && n < 20) begin tick; n++; end
      check("t3_rst_len", 32'(n), 32'd4);
      n = 0;
      while (!done_a && n < 300) begin
         pc = (n < 10) ? 32'(n * 4) : 32'h28;
         tick; n++;
      end
      check("t3_run_len", 32'(n), 32'd18);
      check("t3_st", 32'(st_a), S_HALT);
      check("t3_cnt", cycle_count_a, 32'd18);

      // Halt and timeout on the same clock (RUN_CYCLES=8)
      start_b = 1'b1; tick; start_b = 1'b0;
      n = 0;
      while (!running_b && n < 20) begin tick; n++; end
      check("t4_rst_len", 32'(n), 32'd4);
      n = 0;
      while (!done_b && n < 100) begin pc = 32'h100; tick; n++; end
      check("t4_run_len", 32'(n), 32'd8);
      check("t4_st", 32'(st_b), S_HALT);
      check("t4_cnt", cycle_count_b, 32'd8);

      // Abort together with start on RUN clock 30
      start_a = 1'b1; tick; start_a = 1'b0;
      n = 0;
      while (!running_a && n < 20) begin tick; n++; end
      check("t5_rst_len", 32'(n), 32'd4);
      for (int k = 1; k < 30; k++) begin pc = 32'(k * 4); tick; end
      pc = 32'h1000; abort_a = 1'b1; start_a = 1'b1;
      tick;
      abort_a = 1'b0; start_a = 1'b0;
      check("t5_st", 32'(st_a), S_IDLE);
      check("t5_cnt", cycle_count_a, 32'd30);
      for (int i = 0; i < 2; i++) begin
         tick;
         check("t5_hold_st", 32'(st_a), S_IDLE);
         check("t5_hold_cnt", cycle_count_a, 32'd30);
      end

      // Async reset mid-RUN at clock 50, then full run and restart from DONE
      start_a = 1'b1; tick; start_a = 1'b0;
      n = 0;
      while (!running_a && n < 20) begin tick; n++; end
      check("t6_rst_len", 32'(n), 32'd4);
      for (int k = 1; k < 50; k++) begin pc = 32'(k * 4); tick; end
      check("t6_pre_cnt", cycle_count_a, 32'd49);
      #2 reset = 1'b0;
      #1;
      check("t6_async_st", 32'(st_a), S_IDLE);
      check("t6_async_cnt", cycle_count_a, 32'd0);
      check("t6_async_b", 32'(st_b), S_IDLE);
      tick; tick;
      reset = 1'b1;
      tick;
      check("t6_post_st", 32'(st_a), S_IDLE);
      start_a = 1'b1; tick; start_a = 1'b0;
      n = 0;
      while (!running_a && n < 20) begin tick; n++; end
      check("t6_rst_len2", 32'(n), 32'd4);
      n = 0;
      while (!done_a && n < 300) begin pc = 32'(n * 4); tick; n++; end
      check("t6_run_len", 32'(n), 32'd100);
      check("t6_st", 32'(st_a), S_TIMEOUT);
      start_a = 1'b1; tick; start_a = 1'b0;
      check("t6_restart_st", 32'(st_a), S_IDLE);
      n = 0;
      while (!running_a && n < 20) begin tick; n++; end
      check("t6_rst_len3", 32'(n), 32'd4);
      check("t6_run_st", 32'(st_a), 32'h08);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter PC_WIDTH, 32, width of the monitored CPU instruction address.
REQ-002 SHALL have parameter RESET_CYCLES, 4, CPU reset pulse length in clocks (legal 1..255).
REQ-003 SHALL have parameter RUN_CYCLES, 1000, run budget in clocks before timeout (legal 1..2^32-1).
REQ-004 SHALL have parameter STALL_LIMIT, 8, consecutive unchanged-PC clocks that declare a halt (legal 2..65535).
REQ-005 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-clock pulse; begins a run from IDLE or DONE.
REQ-008 SHALL have port abort  input  1  one-clock pulse; cancels a run in RESET or RUN.
REQ-009 SHALL have port pc  input  PC_WIDTH  CPU instruction-fetch address (instr_sel).
REQ-010 SHALL have port cpu_reset  output  1  active-high reset driven into cpu_module.
REQ-011 SHALL have port running  output  1  high only in RUN.
REQ-012 SHALL have port done  output  1  high only in DONE.
REQ-013 SHALL have port halted  output  1  run ended by PC stall; valid while done.
REQ-014 SHALL have port timeout  output  1  run ended by budget exhaustion; valid while done.
REQ-015 SHALL have port cycle_count  output  32  clocks spent in RUN for the current/last run.

Function
REQ-016 SHALL implement states IDLE, RESET, RUN, DONE; cpu_reset=1 in every state except RUN.
REQ-017 SHALL move IDLE->RESET or DONE->RESET on start, clearing halted, timeout, cycle_count, stall counter.
REQ-018 SHALL hold RESET for exactly RESET_CYCLES clocks, then enter RUN; start ignored in RESET and RUN.
REQ-019 SHALL increment cycle_count by 1 each RUN clock, saturating at 32'hFFFFFFFF.
REQ-020 SHALL register pc each RUN clock; first RUN clock loads the register and clears the stall counter (no compare).
REQ-021 SHALL increment stall counter when pc equals registered pc, else clear it; reaching STALL_LIMIT-1 matches -> DONE with halted=1.
REQ-022 SHALL enter DONE with timeout=1 when cycle_count reaches RUN_CYCLES.
REQ-023 SHALL, on simultaneous halt and timeout conditions, set halted=1 and timeout=0.
REQ-024 SHALL, on abort in RESET or RUN, go to IDLE next clock with halted, timeout cleared and cycle_count frozen; abort ignored in IDLE/DONE; abort wins over start.
REQ-025 SHALL hold done, halted, timeout, cycle_count stable in DONE until the next start.
REQ-026 SHALL register all outputs (no combinational input-to-output path).

Reset
REQ-027 SHALL on reset low asynchronously force IDLE, cpu_reset=1, running=0, done=0, halted=0, timeout=0, cycle_count=0, stall counter=0, registered pc=0, signature=0.
REQ-028 SHALL leave reset synchronously; first state change no earlier than the first rising clock after deassertion.

Configuration
REQ-029 SHALL, with RUN_CTRL_SIGNATURE_EN defined, add output signature (32) = rotate-left-1 of itself XOR zero-extended/truncated pc each RUN clock, cleared on start, held in DONE.
REQ-030 SHALL, without RUN_CTRL_SIGNATURE_EN, omit the signature port and logic entirely; all other behaviour identical.

Structure
REQ-031 SHALL take the state enum, status encodings and the signature rotate function from shared package run_ctrl_pkg.
REQ-032 SHALL place PC compare, registered pc and stall counter in sub-module stall_detector (inputs clock, reset, clear, enable, pc; output stalled).

Verification (RESET_CYCLES=4, RUN_CYCLES=100, STALL_LIMIT=8)
REQ-033 SHALL check: reset low then high, no start -> IDLE held, cpu_reset=1, all other outputs 0 for 20 clocks.
REQ-034 SHALL check: start, pc increments by 4 every clock -> cpu_reset high 4 clocks, timeout=1, halted=0, cycle_count=100, done held.
REQ-035 SHALL check: start, pc advances 10 clocks then sticks at 0x28 -> halted=1 after 8 clocks on 0x28, timeout=0, cycle_count=18.
REQ-036 SHALL check: RUN_CYCLES=8 with pc stuck from first RUN clock -> halt and timeout coincide, halted=1, timeout=0.
REQ-037 SHALL check: abort at RUN clock 30 together with start -> IDLE next clock, cpu_reset=1, cycle_count=30, done=0.
REQ-038 SHALL check: reset low mid-RUN at clock 50, then start from DONE after re-run -> outputs cleared asynchronously, restart repeats the 4-clock reset pulse.
